// File: rtl/bitcount_fu.sv
// Multi-cycle CPOP/CLZ/CTZ functional unit on the issue/writeback protocol.
// One operation in flight; CHUNK bits of the operand are reduced per cycle.
module bitcount_fu #(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned CHUNK         = 8,
    parameter int unsigned TRANS_ID_BITS = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [1:0]               op_i,
    input  logic [XLEN-1:0]          operand_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic [XLEN-1:0]          result_o,
    output logic [TRANS_ID_BITS-1:0] trans_id_o,
    output logic                     valid_o,
    output logic                     ex_valid_o
);

    localparam int unsigned N  = XLEN / CHUNK;
    localparam int unsigned NW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam int unsigned KW = $clog2(CHUNK) + 1;

    localparam logic [1:0] OP_CPOP = 2'b00;
    localparam logic [1:0] OP_CLZ  = 2'b01;
    localparam logic [1:0] OP_RSV  = 2'b11;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                   state;
    logic [XLEN-1:0]          shreg;
    logic [CW-1:0]            acc;
    logic                     found;
    logic [NW-1:0]            cnt;
    logic [1:0]               op_q;
    logic [TRANS_ID_BITS-1:0] tid_q;
    logic                     ex_q;

    logic [XLEN-1:0]  rev;
    logic [CHUNK-1:0] chunk;
    logic [KW-1:0]    pop;
    logic [KW-1:0]    tz;
    logic [CW-1:0]    acc_next;

    // CLZ is computed as CTZ of the bit-reversed operand
    always_comb begin
        for (int i = 0; i < XLEN; i++) begin
            rev[i] = operand_i[XLEN-1-i];
        end
    end

    // Per-chunk popcount and trailing-zero count, folded into the accumulator
    always_comb begin
        chunk = shreg[CHUNK-1:0];
        pop   = '0;
        tz    = KW'(CHUNK);
        for (int i = 0; i < CHUNK; i++) begin
            pop = pop + KW'(chunk[i]);
        end
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (chunk[i]) tz = KW'(i);
        end
        if (op_q == OP_CPOP)  acc_next = acc + CW'(pop);
        else if (!found)      acc_next = acc + CW'(tz);
        else                  acc_next = acc;
    end

    assign ready_o    = (state == IDLE) && !rst_i;
    assign valid_o    = (state == DONE) && !flush_i;
    assign ex_valid_o = (state == DONE) && ex_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            shreg      <= '0;
            acc        <= '0;
            found      <= 1'b0;
            cnt        <= '0;
            op_q       <= '0;
            tid_q      <= '0;
            ex_q       <= 1'b0;
            result_o   <= '0;
            trans_id_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i && !flush_i) begin
                        op_q  <= op_i;
                        tid_q <= trans_id_i;
                        shreg <= (op_i == OP_CLZ) ? rev : operand_i;
                        acc   <= '0;
                        found <= 1'b0;
                        cnt   <= '0;
                        if (op_i == OP_RSV) begin
                            ex_q       <= 1'b1;
                            result_o   <= '0;
                            trans_id_o <= trans_id_i;
                            state      <= DONE;
                        end else begin
                            ex_q  <= 1'b0;
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else begin
                        shreg <= shreg >> CHUNK;
                        acc   <= acc_next;
                        found <= found | (|chunk);
                        cnt   <= cnt + NW'(1);
                        // Last chunk: publish the final count with the writeback
                        if (cnt == NW'(N - 1)) begin
                            result_o   <= XLEN'(acc_next);
                            trans_id_o <= tid_q;
                            state      <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitcount_fu.sv
// Directed, table-driven bench for bitcount_fu with flush/reset/back-to-back sequences.
module tb_bitcount_fu;

    localparam logic [1:0] OP_CPOP = 2'b00;
    localparam logic [1:0] OP_CLZ  = 2'b01;
    localparam logic [1:0] OP_CTZ  = 2'b10;
    localparam logic [1:0] OP_RSV  = 2'b11;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [1:0]  op_i = '0;
    logic [63:0] operand_i = '0;
    logic [2:0]  trans_id_i = '0;
    logic [63:0] result_o;
    logic [2:0]  trans_id_o;
    logic        valid_o;
    logic        ex_valid_o;

    int checks = 0;
    int errors = 0;

    bitcount_fu #(.XLEN(64), .CHUNK(8), .TRANS_ID_BITS(3)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .op_i       (op_i),
        .operand_i  (operand_i),
        .trans_id_i (trans_id_i),
        .result_o   (result_o),
        .trans_id_o (trans_id_o),
        .valid_o    (valid_o),
        .ex_valid_o (ex_valid_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  op;
        logic [63:0] opnd;
        logic [2:0]  tid;
        logic [63:0] res;
        logic        ex;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present an operation at the current negedge; returns at the first negedge after accept
    task automatic start_op(input logic [1:0] op, input logic [63:0] opnd, input logic [2:0] tid);
        op_i = op; operand_i = opnd; trans_id_i = tid; valid_i = 1'b1;
        @(negedge clk_i);
        valid_i = 1'b0;
    endtask

    task automatic watch_none(input int cycles, input string name);
        logic seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk_i);
            if (valid_o) seen = 1'b1;
        end
        check(name, 64'(seen), 64'd0);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [63:0] opnd, input logic [2:0] tid,
                          input logic [63:0] exp_res, input logic exp_ex, input int exp_lat,
                          input string name);
        int          lat;
        logic        rdy_bad;
        logic [63:0] res;
        logic [2:0]  t;
        logic        ex;
        lat = 0; rdy_bad = 1'b0; res = 'x; t = 'x; ex = 1'bx;
        check({name, "_ready_idle"}, 64'(ready_o), 64'd1);
        op_i = op; operand_i = opnd; trans_id_i = tid; valid_i = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_i);
            valid_i = 1'b0;
            if (valid_o) begin
                lat = k; res = result_o; t = trans_id_o; ex = ex_valid_o;
                break;
            end
            if (ready_o) rdy_bad = 1'b1;
        end
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_result"}, res, exp_res);
        check({name, "_trans_id"}, 64'(t), 64'(tid));
        check({name, "_ex_valid"}, 64'(ex), 64'(exp_ex));
        check({name, "_ready_low_busy"}, 64'(rdy_bad), 64'd0);
        @(negedge clk_i);
        check({name, "_pulse_one_cycle"}, 64'(valid_o), 64'd0);
        check({name, "_ready_after"}, 64'(ready_o), 64'd1);
        check({name, "_result_hold"}, result_o, res);
    endtask

    logic [63:0] b2b_opnd[3];
    logic [1:0]  b2b_op[3];
    logic [2:0]  b2b_tid[3];
    logic [63:0] b2b_res[3];

    initial begin
        vecs[0]  = '{OP_CPOP, 64'hF0F0_0000_0000_0001, 3'd5, 64'd9,  1'b0, 9, "cpop_mixed"};
        vecs[1]  = '{OP_CLZ,  64'h0000_0100_0000_0000, 3'd1, 64'd23, 1'b0, 9, "clz_bit40"};
        vecs[2]  = '{OP_CTZ,  64'h0000_0100_0000_0000, 3'd6, 64'd40, 1'b0, 9, "ctz_bit40"};
        vecs[3]  = '{OP_CLZ,  64'h0,                   3'd2, 64'd64, 1'b0, 9, "clz_zero"};
        vecs[4]  = '{OP_CTZ,  64'h0,                   3'd3, 64'd64, 1'b0, 9, "ctz_zero"};
        vecs[5]  = '{OP_CPOP, 64'h0,                   3'd4, 64'd0,  1'b0, 9, "cpop_zero"};
        vecs[6]  = '{OP_CLZ,  64'hFFFF_FFFF_FFFF_FFFF, 3'd7, 64'd0,  1'b0, 9, "clz_ones"};
        vecs[7]  = '{OP_CTZ,  64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 64'd0,  1'b0, 9, "ctz_ones"};
        vecs[8]  = '{OP_CPOP, 64'hFFFF_FFFF_FFFF_FFFF, 3'd5, 64'd64, 1'b0, 9, "cpop_ones"};
        vecs[9]  = '{OP_RSV,  64'hDEAD_BEEF_0000_1234, 3'd2, 64'd0,  1'b1, 1, "reserved_op"};
        vecs[10] = '{OP_CLZ,  64'h1,                   3'd6, 64'd63, 1'b0, 9, "clz_one"};
        vecs[11] = '{OP_CTZ,  64'h8000_0000_0000_0000, 3'd1, 64'd63, 1'b0, 9, "ctz_msb"};
        vecs[12] = '{OP_CPOP, 64'hAAAA_AAAA_AAAA_AAAA, 3'd3, 64'd32, 1'b0, 9, "cpop_alt"};

        b2b_op[0] = OP_CPOP; b2b_opnd[0] = 64'h7;                   b2b_tid[0] = 3'd1; b2b_res[0] = 64'd3;
        b2b_op[1] = OP_CTZ;  b2b_opnd[1] = 64'h100;                 b2b_tid[1] = 3'd2; b2b_res[1] = 64'd8;
        b2b_op[2] = OP_CLZ;  b2b_opnd[2] = 64'h0000_FFFF_FFFF_FFFF; b2b_tid[2] = 3'd3; b2b_res[2] = 64'd16;

        // Reset state
        repeat (3) @(negedge clk_i);
        check("rst_result", result_o, 64'd0);
        check("rst_trans_id", 64'(trans_id_o), 64'd0);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_ex_valid", 64'(ex_valid_o), 64'd0);
        check("rst_ready_low", 64'(ready_o), 64'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_ready_after", 64'(ready_o), 64'd1);

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].opnd, vecs[i].tid, vecs[i].res,
                   vecs[i].ex, vecs[i].lat, vecs[i].name);
        end

        // Flush during BUSY cycle 4
        start_op(OP_CPOP, 64'hFFFF_FFFF_FFFF_FFFF, 3'd6);
        repeat (3) @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        check("flush_busy_ready", 64'(ready_o), 64'd1);
        watch_none(12, "flush_busy_no_wb");
        run_op(OP_CTZ, 64'h8, 3'd4, 64'd3, 1'b0, 9, "after_flush_busy");

        // Flush during DONE
        start_op(OP_CPOP, 64'hFF, 3'd3);
        repeat (7) @(negedge clk_i);
        @(posedge clk_i);
        #1 flush_i = 1'b1;
        @(negedge clk_i);
        check("flush_done_valid", 64'(valid_o), 64'd0);
        @(negedge clk_i);
        flush_i = 1'b0;
        check("flush_done_ready", 64'(ready_o), 64'd1);
        watch_none(12, "flush_done_no_wb");
        run_op(OP_CTZ, 64'h8, 3'd1, 64'd3, 1'b0, 9, "after_flush_done");

        // valid_i held high with inputs changing every non-IDLE cycle
        begin
            int idx, wb, last_acc;
            idx = 0; wb = 0; last_acc = -1;
            for (int cyc = 0; cyc < 80 && wb < 3; cyc++) begin
                if (valid_o) begin
                    if (wb < 3) begin
                        check($sformatf("b2b_result_%0d", wb), result_o, b2b_res[wb]);
                        check($sformatf("b2b_trans_id_%0d", wb), 64'(trans_id_o), 64'(b2b_tid[wb]));
                    end
                    wb++;
                end
                if (ready_o && idx < 3) begin
                    op_i = b2b_op[idx]; operand_i = b2b_opnd[idx]; trans_id_i = b2b_tid[idx];
                    valid_i = 1'b1;
                    if (last_acc >= 0) check($sformatf("b2b_spacing_%0d", idx), 64'(cyc - last_acc), 64'd10);
                    last_acc = cyc;
                    idx++;
                end else if (idx < 3) begin
                    op_i = 2'($urandom); operand_i = {$urandom, $urandom}; trans_id_i = 3'($urandom);
                    valid_i = 1'b1;
                end else begin
                    valid_i = 1'b0;
                end
                @(negedge clk_i);
            end
            valid_i = 1'b0;
            check("b2b_writebacks", 64'(wb), 64'd3);
        end
        repeat (2) @(negedge clk_i);

        // valid_i together with flush_i in IDLE is not accepted
        op_i = OP_CPOP; operand_i = 64'hFF; trans_id_i = 3'd5; valid_i = 1'b1; flush_i = 1'b1;
        @(negedge clk_i);
        check("idle_flush_no_accept", 64'(ready_o), 64'd1);
        valid_i = 1'b0; flush_i = 1'b0;
        watch_none(12, "idle_flush_no_wb");

        // Reset asserted mid-BUSY
        start_op(OP_CPOP, 64'hFFFF_FFFF_FFFF_FFFF, 3'd7);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("midrst_result", result_o, 64'd0);
        check("midrst_trans_id", 64'(trans_id_o), 64'd0);
        check("midrst_valid", 64'(valid_o), 64'd0);
        check("midrst_ex_valid", 64'(ex_valid_o), 64'd0);
        check("midrst_ready_low", 64'(ready_o), 64'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("midrst_ready_after", 64'(ready_o), 64'd1);
        watch_none(12, "midrst_no_wb");
        run_op(OP_CPOP, 64'h3, 3'd1, 64'd2, 1'b0, 9, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bitcount_fu.md
Name: bitcount_fu

Overview:
- Multi-cycle functional unit on the responder end of the issue/writeback protocol.
- Accepts one issued operation (valid/ready with trans_id) and computes CPOP, CLZ or CTZ on an XLEN-bit operand, processing CHUNK bits per cycle.
- Returns the result on one writeback port (result, trans_id, valid, exception) consumed by the scoreboard.
- Holds one operation in flight at a time; flush discards it.

Parameters:
- XLEN, 64, operand/result width.
- CHUNK, 8, bits processed per cycle. Must be a power of 2 and divide XLEN.
- TRANS_ID_BITS, 3, scoreboard transaction-ID width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- flush_i  in  1  kill in-flight operation
- valid_i  in  1  issue valid
- ready_o  out  1  unit can accept an operation
- op_i  in  2  00 CPOP, 01 CLZ, 10 CTZ, 11 reserved
- operand_i  in  XLEN  source operand
- trans_id_i  in  TRANS_ID_BITS  scoreboard ID of the issued operation
- result_o  out  XLEN  writeback data
- trans_id_o  out  TRANS_ID_BITS  writeback ID
- valid_o  out  1  writeback valid, one-cycle pulse
- ex_valid_o  out  1  illegal-instruction exception flag for this writeback

Behaviour:
- Reset (rst_i high at an edge):
  - FSM goes to IDLE; internal state clears.
  - result_o=0, trans_id_o=0, valid_o=0, ex_valid_o=0.
  - ready_o=0 while rst_i is high, then 1 in IDLE.
  - Reset overrides all other inputs, including mid-operation.
- FSM states: IDLE, BUSY, DONE. ready_o = (state==IDLE) & ~rst_i.
- IDLE:
  - Accept when valid_i & ready_o & ~flush_i.
  - On accept, latch op and trans_id. The shift register takes operand_i, bit-reversed for CLZ so that CLZ reduces to CTZ.
  - Clear accumulator, found flag and chunk counter.
  - Valid op goes to BUSY. op 11 goes to DONE with ex_valid set and result 0.
- BUSY, once per cycle:
  - Examine the low CHUNK bits of the shift register, then shift right by CHUNK.
  - CPOP: add the popcount of the chunk.
  - CTZ/CLZ: if found=0, add the trailing-zero count of the chunk; set found if the chunk is nonzero. If found=1, hold the accumulator.
  - Chunk counter counts 0..N-1, where N=XLEN/CHUNK. At count N-1, go to DONE.
- DONE:
  - valid_o=1 for exactly one cycle; result_o = accumulator zero-extended to XLEN (count width $clog2(XLEN)+1).
  - trans_id_o = latched ID; ex_valid_o = latched exception flag.
  - Next state is IDLE. No accept happens in DONE.
- Latency:
  - Accept at edge t gives BUSY for cycles t+1..t+N and valid_o high in cycle t+N+1.
  - Defaults: valid_o 9 cycles after the accept edge.
  - Reserved op: valid_o in cycle t+1.
  - Back-to-back issue: next accept no earlier than the cycle after DONE.
- Boundary results:
  - Operand 0: CPOP=0, CLZ=XLEN, CTZ=XLEN.
  - All-ones: CPOP=XLEN, CLZ=0, CTZ=0.
  - Accumulator must not overflow at value XLEN.
- Flush:
  - flush_i in BUSY or DONE forces IDLE at the next edge.
  - valid_o is gated by ~flush_i in DONE, so no writeback from a flushed operation.
  - flush_i with valid_i in IDLE means no accept.
  - ready_o is unaffected by flush_i.
- Outputs between writebacks:
  - result_o and trans_id_o hold their last values.
  - valid_o=0 and ex_valid_o=0 outside DONE (ex_valid_o = DONE & latched flag).

Test Plan:
1. CPOP, operand 0xF0F0_0000_0000_0001, trans_id 5 -> valid_o pulse exactly 9 cycles after accept; result 9; trans_id_o 5; ex_valid_o 0; ready_o low during BUSY/DONE.
2. CLZ/CTZ on operand 0x0000_0100_0000_0000 -> CLZ=23, CTZ=40. Operand 0 -> both 64, CPOP 0. Operand all-ones -> CLZ 0, CTZ 0, CPOP 64.
3. op 11, trans_id 2 -> valid_o in the cycle after accept; ex_valid_o 1; result 0; trans_id_o 2.
4. Flush in BUSY cycle 4, and separately flush in DONE -> no valid_o pulse in either case; ready_o 1 on the next cycle; a following CTZ of 0x8 returns 3 with the correct trans_id.
5. valid_i held high continuously with changing operands/IDs -> accepts only in IDLE cycles, one per 10 cycles; each writeback matches its own operand and ID. valid_i with flush_i in IDLE -> not accepted.
6. rst_i asserted mid-BUSY -> all outputs 0 the next cycle, no writeback; after release ready_o=1 and a fresh CPOP of 0x3 returns 2.
